// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding, entry-point table and default widths for the PC sequencer.
package pc_sequencer_pkg;
  localparam int DEF_PC_W = 10;
  localparam int DEF_IMEM_DEPTH = 1024;
  localparam int DEF_CNT_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} pc_state_t;
  localparam logic [DEF_PC_W-1:0] START_ADDR [4] = '{10'd0, 10'd128, 10'd256, 10'd384};
  function automatic logic [DEF_PC_W-1:0] start_addr(input logic [1:0] sel);
    return START_ADDR[sel];
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: run-control, ALU-result and status signals between testbench/ALU and the sequencer.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic start;
  logic [1:0] prog_sel;
  logic stall;
  logic [8:0] boffset;
  logic bsign;
  logic alu_reset;
  logic alu_halt;
  logic [PC_W-1:0] pc;
  logic fetch_en;
  logic done;
  logic fault;
  logic [CNT_W-1:0] retired;
  modport master (
    output start, prog_sel, stall, boffset, bsign, alu_reset, alu_halt,
    input pc, fetch_en, done, fault, retired
  );
  modport slave (
    input start, prog_sel, stall, boffset, bsign, alu_reset, alu_halt,
    output pc, fetch_en, done, fault, retired
  );
endinterface

// File: rtl/pc_sequencer_next_calc.sv
// pc_next_calc: combinational next-PC for sequential or relative-branch flow, flagging targets outside instruction memory.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH
) (
  input  logic [PC_W-1:0] pc,
  input  logic [8:0]      boffset,
  input  logic            bsign,
  output logic [PC_W-1:0] nxt,
  output logic            oob
);
  localparam int W = PC_W + 2;
  logic signed [W-1:0] base, off, t;
  always_comb begin
    base = $signed({2'b00, pc});
    off = $signed({{(W-9){1'b0}}, boffset});
    t = (boffset == 9'd0) ? base + W'(1) : bsign ? base - off : base + off;
    oob = (t < 0) || (t > $signed(W'(IMEM_DEPTH - 1)));
    nxt = t[PC_W-1:0];
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, IDLE/RUN/HALTED run control and saturating retire counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  pc_state_t state;
  logic [PC_W-1:0] pc, nxt, entry;
  logic oob, fault;
  logic [CNT_W-1:0] retired;
  pc_next_calc #(.PC_W(PC_W), .IMEM_DEPTH(IMEM_DEPTH)) u_calc (
    .pc(pc), .boffset(bus.boffset), .bsign(bus.bsign), .nxt(nxt), .oob(oob)
  );
  assign entry = PC_W'(start_addr(bus.prog_sel));
  assign bus.pc = pc;
  assign bus.fault = fault;
  assign bus.retired = retired;
  assign bus.fetch_en = (state == RUN) && !bus.stall;
  assign bus.done = (state == HALTED);
  // Any transition into IDLE reloads the entry point and clears status, so IDLE always looks fresh.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      fault <= 1'b0;
      retired <= '0;
    end else case (state)
      RUN: if (bus.start) begin
        state <= IDLE;
        pc <= entry;
        fault <= 1'b0;
        retired <= '0;
      end else begin
        if (!bus.stall || bus.alu_halt || bus.alu_reset)
          retired <= (&retired) ? retired : retired + CNT_W'(1);
        if (bus.alu_halt) state <= HALTED;
        else if (bus.alu_reset) pc <= entry;
        else if (!bus.stall) begin
          if (oob) begin
            fault <= 1'b1;
            state <= HALTED;
          end else pc <= nxt;
        end
      end
      HALTED: if (bus.start) begin
        state <= IDLE;
        pc <= entry;
        fault <= 1'b0;
        retired <= '0;
      end
      default: begin
        pc <= entry;
        fault <= 1'b0;
        retired <= '0;
        state <= bus.start ? IDLE : RUN;
      end
    endcase
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer run control, branching, faults and async reset.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int fails = 0;
  pc_sequencer_if bus ();
  pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic status(input string tag, input int pc, input int fe, input int dn, input int ft, input int rt);
    chk({tag, ".pc"}, 32'(bus.pc), 32'(pc));
    chk({tag, ".fetch_en"}, 32'(bus.fetch_en), 32'(fe));
    chk({tag, ".done"}, 32'(bus.done), 32'(dn));
    chk({tag, ".fault"}, 32'(bus.fault), 32'(ft));
    chk({tag, ".retired"}, 32'(bus.retired), 32'(rt));
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.prog_sel = 2'd1;
    bus.stall = 1'b0;
    bus.boffset = 9'd0;
    bus.bsign = 1'b0;
    bus.alu_reset = 1'b0;
    bus.alu_halt = 1'b0;
    #1;
    status("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    status("idle", 128, 0, 0, 0, 0);
    bus.start = 1'b0;
    tick();
    status("run_entry", 128, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq.pc", 32'(bus.pc), 32'(128 + i));
    end
    chk("seq.retired", 32'(bus.retired), 32'd5);
    bus.boffset = 9'd67;
    tick();
    chk("fwd_to_200", 32'(bus.pc), 32'd200);
    bus.boffset = 9'h00A;
    tick();
    status("fwd_to_210", 210, 1, 0, 0, 7);
    bus.boffset = 9'h0FF;
    bus.bsign = 1'b1;
    tick();
    status("neg_fault", 210, 0, 1, 1, 8);
    bus.boffset = 9'd3;
    bus.bsign = 1'b0;
    bus.alu_reset = 1'b1;
    tick();
    status("halted_hold", 210, 0, 1, 1, 8);
    bus.alu_reset = 1'b0;
    bus.start = 1'b1;
    tick();
    status("restart_idle", 128, 0, 0, 0, 0);
    bus.start = 1'b0;
    bus.boffset = 9'd12;
    tick();
    chk("rerun.pc", 32'(bus.pc), 32'd128);
    tick();
    chk("to_140", 32'(bus.pc), 32'd140);
    bus.alu_halt = 1'b1;
    bus.alu_reset = 1'b1;
    tick();
    status("halt_wins", 140, 0, 1, 0, 2);
    bus.alu_halt = 1'b0;
    bus.alu_reset = 1'b0;
    bus.start = 1'b1;
    tick();
    status("halt_restart", 128, 0, 0, 0, 0);
    bus.prog_sel = 2'd2;
    tick();
    chk("sel2_idle", 32'(bus.pc), 32'd256);
    bus.start = 1'b0;
    bus.boffset = 9'd44;
    tick();
    chk("sel2_run", 32'(bus.pc), 32'd256);
    tick();
    chk("to_300", 32'(bus.pc), 32'd300);
    bus.alu_reset = 1'b1;
    tick();
    status("soft_reset", 256, 1, 0, 0, 2);
    bus.alu_reset = 1'b0;
    bus.stall = 1'b1;
    bus.boffset = 9'd5;
    #1;
    chk("stall.fetch_en", 32'(bus.fetch_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      status("stall", 256, 0, 0, 0, 2);
    end
    bus.stall = 1'b0;
    tick();
    chk("post_stall", 32'(bus.pc), 32'd261);
    bus.boffset = 9'd511;
    tick();
    chk("to_772", 32'(bus.pc), 32'd772);
    bus.boffset = 9'd251;
    tick();
    status("to_1023", 1023, 1, 0, 0, 5);
    bus.boffset = 9'd0;
    tick();
    status("top_fault", 1023, 0, 1, 1, 6);
    bus.start = 1'b1;
    tick();
    chk("idle_sel2", 32'(bus.pc), 32'd256);
    bus.prog_sel = 2'd3;
    bus.start = 1'b0;
    tick();
    chk("sel3_run", 32'(bus.pc), 32'd384);
    tick();
    chk("sel3_step", 32'(bus.pc), 32'd385);
    #2;
    rst_n = 1'b0;
    #1;
    status("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    status("reset_held", 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    status("post_reset", 384, 1, 0, 0, 0);
    tick();
    status("post_reset_run", 385, 1, 0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage directly downstream of the ALU. Each cycle it takes the ALU's branch-offset, sign, soft-reset and halt outputs for the instruction at the current PC and registers the next PC, which addresses instruction memory. It also runs the IDLE/RUN/HALTED lifecycle and gives the testbench a START/DONE handshake. The core is single-cycle: one instruction retires per non-stalled RUN cycle.

## Interface
- PC_W, 10, PC and instruction-memory address width.
- IMEM_DEPTH, 1024, number of valid instruction words; legal PCs are 0..IMEM_DEPTH-1.
- CNT_W, 16, retired-instruction counter width.
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  level from testbench; high holds the core in IDLE, low lets it run.
- PROG_SEL  input  2  selects the entry address from the package start-address table.
- STALL  input  1  holds PC for one cycle; nothing retires.
- bOFFSET  input  9  ALU branch offset (magnitude); 0 means sequential.
- bSIGN  input  1  ALU offset sign; 1 means backward.
- ALU_RESET  input  1  ALU soft-reset request (reset output).
- ALU_HALT  input  1  ALU halt request (halt output).
- PC  output  PC_W  current instruction address.
- FETCH_EN  output  1  high in RUN when STALL is low.
- DONE  output  1  high in HALTED.
- FAULT  output  1  sticky flag: an out-of-range target was computed.
- RETIRED  output  CNT_W  count of retired instructions; saturates at all-ones.

## Operation
- States are IDLE, RUN and HALTED. The encoding is the package enum `pc_state_t`.
- IDLE:
  - PC = start_addr[PROG_SEL], re-sampled every cycle.
  - RETIRED = 0 and FAULT = 0.
  - START low moves to RUN on the next edge.
- RUN: the next PC is chosen by the first matching rule below, in priority order.
  1. START high: go to IDLE.
  2. ALU_HALT high: go to HALTED; PC holds; the halting instruction counts as retired. ALU_HALT wins over ALU_RESET when both are high.
  3. ALU_RESET high (and ALU_HALT low): PC = start_addr[PROG_SEL]; stay in RUN; counts as retired.
  4. STALL high: PC holds; no retire.
  5. bOFFSET == 0: PC + 1.
  6. Otherwise: target = PC + bOFFSET when bSIGN = 0, or PC - bOFFSET when bSIGN = 1.
- Target arithmetic:
  - Computed in signed PC_W+2 bits.
  - A target below 0, or above IMEM_DEPTH-1, sets FAULT, goes to HALTED, and PC holds.
  - There is no wrap-around.
  - PC + 1 from IMEM_DEPTH-1 is also a fault.
- HALTED:
  - PC, RETIRED and FAULT hold; DONE = 1.
  - START high moves to IDLE on the next edge.
  - All ALU inputs are ignored.
- RETIRED increments on every non-stalled RUN cycle that does not leave RUN for IDLE. It saturates and does not wrap.

## Timing
- Reset values: state = IDLE, PC = 0, FETCH_EN = 0, DONE = 0, FAULT = 0, RETIRED = 0.
- Reset is asynchronous mid-operation: assertion clears all state immediately, regardless of the clock.
- After RESET_N deasserts, the first edge loads PC = start_addr[PROG_SEL] (IDLE behaviour).
- PC, state and RETIRED are registered.
- FETCH_EN and DONE are decoded from registered state plus STALL only. There is no combinational path from bOFFSET, bSIGN, ALU_RESET or ALU_HALT to any output.
- Latency: an ALU result produced during cycle n is reflected in PC at cycle n+1.
- Handshake timing:
  - START falling edge to the first FETCH_EN: 1 cycle.
  - ALU_HALT sampled to DONE: 1 cycle.
- Inputs are assumed synchronous to CLK. The ALU inputs are meaningful only while FETCH_EN = 1.

## Structure
- Add to the shared definitions package:
  - `pc_state_t` enum (IDLE, RUN, HALTED);
  - localparam array `START_ADDR[4]` of entry points, values 0, 128, 256, 384;
  - the default PC_W and IMEM_DEPTH values.
- One sub-module, `pc_next_calc`: purely combinational. It takes PC, bOFFSET and bSIGN and produces the next PC plus an out-of-range flag. The FSM, PC register and counter stay in `pc_sequencer`.

## Test plan
- Sequential run: PROG_SEL = 1, START 1→0, bOFFSET = 0 for 5 cycles. Expect PC 128,129,130,131,132,133 and RETIRED = 5.
- Branches:
  - PC = 200, bOFFSET = 9'h00A, bSIGN = 0 → PC = 210.
  - Then bOFFSET = 9'h0FF, bSIGN = 1 → fault. DONE = 1, FAULT = 1, PC holds 210.
- Halt and restart:
  - ALU_HALT = 1 and ALU_RESET = 1 at PC = 140. Next cycle: DONE = 1 and PC = 140.
  - START pulse → IDLE, PC reloads to start_addr[PROG_SEL]. FAULT = 0.
- Soft reset and stall:
  - ALU_RESET = 1 at PC = 300 with PROG_SEL = 2 → PC = 256, state stays RUN.
  - STALL high for 3 cycles → PC frozen, FETCH_EN = 0, RETIRED unchanged.
- Upper boundary: PC = 1023 with bOFFSET = 0 → FAULT = 1, HALTED, PC = 1023.
- Async reset: drop RESET_N mid-RUN between clock edges. All outputs are zero immediately; after release, the PC loads the selected start address on the first edge.
